// File: rtl/ntt_bf2x2_stream.sv
// Streaming radix-2x2 NTT butterfly for modular arithmetic.
// Supports forward, inverse and pointwise-multiply modes. Datapath:
//   pre-add (1 cycle) -> six modular multipliers (MUL_LAT) -> post-add (1 cycle)
// so every mode has the same latency, L = MUL_LAT + 2.
// The pipeline cannot stall. A credit counter covers the beats in flight plus
// the FIFO occupancy, so every beat that is accepted is guaranteed a slot in
// the output FIFO.
module ntt_bf2x2_stream #(
  parameter int          WIDTH      = 23,
  parameter int unsigned Q          = 8380417,
  parameter int          MUL_LAT    = 3,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mode_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*WIDTH-1:0]         data_i,
  input  logic [6*WIDTH-1:0]         zeta_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*(WIDTH+1)-1:0]     data_o,
  output logic [2:0]                 out_mode,
  output logic                       busy,
  output logic                       err
);

  localparam int L  = MUL_LAT + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [WIDTH-1:0]   QN = WIDTH'(Q);
  localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

  localparam logic [2:0] MODE_FWD = 3'd0;
  localparam logic [2:0] MODE_INV = 3'd1;
  localparam logic [2:0] MODE_PWM = 3'd2;

  // Both operands must be < Q. Comparing against (Q - b) avoids needing a carry bit.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] gap;
    gap = QN - b;
    if (a >= gap) return a - gap;
    else          return a + b;
  endfunction

  // When a < b the true result Q-(b-a) fits in WIDTH bits, so wrap-around is harmless.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    if (a >= b) return a - b;
    else        return a + (QN - b);
  endfunction

  // ------------------------------------------------------------------
  // Handshake, credit and mode lock
  // ------------------------------------------------------------------
  logic [L-1:0]      vld;
  logic [L-1:0][2:0] mode_sr;
  logic [CW-1:0]     credit;
  logic [CW-1:0]     count;
  logic              lock;
  logic              accept;
  logic              push;
  logic              pop;

  // A beat in its last stage leaves this edge, so it does not block a mode change.
  always_comb begin
    lock = 1'b0;
    for (int i = 0; i < L-1; i++) begin
      if (vld[i] && (mode_sr[i] != mode_i)) lock = 1'b1;
    end
  end

  assign in_ready  = !rst && (credit < CW'(FIFO_DEPTH)) && !lock;
  assign accept    = in_valid && in_ready;
  assign push      = vld[L-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = |vld;

  // Beat-valid shift register, one bit per pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else     vld <= {vld[L-2:0], accept};
  end

  // Mode tag travelling alongside each beat.
  always_ff @(posedge clk) begin
    mode_sr <= {mode_sr[L-2:0], mode_i};
  end

  // Credits: claimed on acceptance, released on the pop edge (so visible next cycle).
  always_ff @(posedge clk) begin
    if (rst) credit <= '0;
    else     credit <= credit + CW'(accept) - CW'(pop);
  end

  // Sticky flag for beats accepted with a reserved mode.
  always_ff @(posedge clk) begin
    if (rst)                            err <= 1'b0;
    else if (accept && mode_i > MODE_PWM) err <= 1'b1;
  end

  // ------------------------------------------------------------------
  // Stage A: pre-add and multiplier operand select
  // ------------------------------------------------------------------
  logic [3:0][WIDTH-1:0] a;
  logic [5:0][WIDTH-1:0] z;
  logic [WIDTH-1:0]      pa_s, pa_d, pa_t, pa_u;
  logic [5:0][WIDTH-1:0] ax, az;
  logic [5:0][WIDTH-1:0] ax_q, az_q;

  assign a = data_i;
  assign z = zeta_i;

  // Select multiplier operands. INV folds its sum/difference layer in here.
  always_comb begin
    pa_s = add_mod(a[0], a[1]);
    pa_d = sub_mod(a[0], a[1]);
    pa_t = add_mod(a[2], a[3]);
    pa_u = sub_mod(a[2], a[3]);
    ax   = '0;
    az   = z;
    case (mode_i)
      MODE_FWD: begin
        ax[0] = a[0];
        ax[1] = a[1];
        ax[2] = a[2];
        ax[3] = a[2];
        ax[4] = a[3];
        ax[5] = a[3];
      end
      MODE_INV: begin
        ax[0] = add_mod(pa_s, pa_t);
        ax[1] = pa_d;
        ax[2] = pa_d;
        ax[3] = pa_u;
        ax[4] = pa_u;
        ax[5] = sub_mod(pa_s, pa_t);
      end
      MODE_PWM: begin
        ax[3:0] = a;
        az[5:4] = '0;
      end
      default: begin
        az = '0;
      end
    endcase
  end

  // Stage A register.
  always_ff @(posedge clk) begin
    ax_q <= ax;
    az_q <= az;
  end

  // ------------------------------------------------------------------
  // Modular multipliers: registered product, reduction, MUL_LAT-1 delays
  // ------------------------------------------------------------------
  logic [5:0][2*WIDTH-1:0] prod_q;
  logic [5:0][WIDTH-1:0]   mres;
  logic [5:0][WIDTH-1:0]   m;

  // Full-width products of the six operand pairs.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 6; j++) begin
      prod_q[j] <= (2*WIDTH)'(ax_q[j]) * (2*WIDTH)'(az_q[j]);
    end
  end

  // Reduction by a constant modulus.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      mres[j] = WIDTH'(prod_q[j] % QW);
    end
  end

  generate
    if (MUL_LAT > 1) begin : g_mul_dly
      logic [MUL_LAT-2:0][5:0][WIDTH-1:0] dly;
      // Remaining multiplier stages; gives retiming room for the reduction.
      always_ff @(posedge clk) begin
        dly[0] <= mres;
        for (int i = 1; i < MUL_LAT-1; i++) dly[i] <= dly[i-1];
      end
      assign m = dly[MUL_LAT-2];
    end else begin : g_mul_nodly
      assign m = mres;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Stage B: post-add
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]      pb_s, pb_d, pb_t, pb_u;
  logic [3:0][WIDTH-1:0] y;
  logic [3:0][WIDTH-1:0] y_q;

  // Combine products according to the mode of the beat now leaving the multipliers.
  always_comb begin
    pb_s = add_mod(m[0], m[1]);
    pb_d = sub_mod(m[0], m[1]);
    pb_t = add_mod(m[2], m[4]);
    pb_u = sub_mod(m[3], m[5]);
    y    = '0;
    case (mode_sr[MUL_LAT])
      MODE_FWD: begin
        y[0] = add_mod(pb_s, pb_t);
        y[1] = sub_mod(pb_s, pb_t);
        y[2] = add_mod(pb_d, pb_u);
        y[3] = sub_mod(pb_d, pb_u);
      end
      MODE_INV: begin
        y[0] = m[0];
        y[1] = add_mod(m[1], m[3]);
        y[2] = sub_mod(m[2], m[4]);
        y[3] = m[5];
      end
      MODE_PWM: begin
        y = m[3:0];
      end
      default: begin
        y = '0;
      end
    endcase
  end

  // Stage B register; its contents are written to the FIFO on the next edge.
  always_ff @(posedge clk) begin
    y_q <= y;
  end

  // ------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ------------------------------------------------------------------
  logic [3:0][WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [2:0]            fifo_mode [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [3:0][WIDTH-1:0] head;

  // FIFO storage; credits guarantee a free slot on every push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= y_q;
      fifo_mode[wr_ptr] <= mode_sr[L-1];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = fifo_data[rd_ptr];

  // Present the head beat. Outputs read zero while the FIFO is empty.
  always_comb begin
    data_o   = '0;
    out_mode = '0;
    if (out_valid) begin
      for (int i = 0; i < 4; i++) begin
        data_o[i*(WIDTH+1) +: (WIDTH+1)] = {1'b0, head[i]};
      end
      out_mode = fifo_mode[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ntt_bf2x2_stream.sv
// Scoreboard bench for ntt_bf2x2_stream: stimulus pushes expected beats,
// a monitor compares every beat the DUT pops.
module tb_ntt_bf2x2_stream;

  localparam int          WIDTH      = 23;
  localparam int unsigned Q          = 8380417;
  localparam longint      QL         = 64'd8380417;
  localparam int          MUL_LAT    = 3;
  localparam int          FIFO_DEPTH = 8;
  localparam int          L          = MUL_LAT + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2:0]             mode_i;
  logic                   in_valid;
  logic                   in_ready;
  logic [4*WIDTH-1:0]     data_i;
  logic [6*WIDTH-1:0]     zeta_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*(WIDTH+1)-1:0] data_o;
  logic [2:0]             out_mode;
  logic                   busy;
  logic                   err;

  ntt_bf2x2_stream #(
    .WIDTH(WIDTH), .Q(Q), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(in_valid), .in_ready(in_ready),
    .data_i(data_i), .zeta_i(zeta_i), .out_valid(out_valid), .out_ready(out_ready),
    .data_o(data_o), .out_mode(out_mode), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]             mode;
    logic [4*(WIDTH+1)-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*(WIDTH+1)-1:0] pack4(input logic [WIDTH-1:0] y0, input logic [WIDTH-1:0] y1,
                                                   input logic [WIDTH-1:0] y2, input logic [WIDTH-1:0] y3);
    return {1'b0, y3, 1'b0, y2, 1'b0, y1, 1'b0, y0};
  endfunction

  function automatic longint md(input longint x);
    return ((x % QL) + QL) % QL;
  endfunction

  // Closed-form reference for the general stream vectors.
  function automatic logic [4*(WIDTH+1)-1:0] model(input logic [2:0] mode, input logic [4*WIDTH-1:0] d,
                                                   input logic [6*WIDTH-1:0] zz);
    longint av[4];
    longint zv[6];
    longint yv[4];
    longint m0, m1, m2, m3, m4, m5, s, dd, t, u;
    for (int i = 0; i < 4; i++) av[i] = longint'(d[i*WIDTH +: WIDTH]);
    for (int j = 0; j < 6; j++) zv[j] = longint'(zz[j*WIDTH +: WIDTH]);
    for (int i = 0; i < 4; i++) yv[i] = 0;
    case (mode)
      3'd0: begin
        m0 = md(av[0]*zv[0]); m1 = md(av[1]*zv[1]); m2 = md(av[2]*zv[2]);
        m3 = md(av[2]*zv[3]); m4 = md(av[3]*zv[4]); m5 = md(av[3]*zv[5]);
        yv[0] = md(m0 + m1 + m2 + m4);
        yv[1] = md(m0 + m1 - m2 - m4);
        yv[2] = md(m0 - m1 + m3 - m5);
        yv[3] = md(m0 - m1 - m3 + m5);
      end
      3'd1: begin
        s = md(av[0] + av[1]); dd = md(av[0] - av[1]);
        t = md(av[2] + av[3]); u  = md(av[2] - av[3]);
        yv[0] = md(md(s + t) * zv[0]);
        yv[3] = md(md(s - t) * zv[5]);
        yv[1] = md(dd * zv[1] + u * zv[3]);
        yv[2] = md(dd * zv[2] - u * zv[4]);
      end
      3'd2: begin
        for (int i = 0; i < 4; i++) yv[i] = md(av[i] * zv[i]);
      end
      default: ;
    endcase
    return pack4(WIDTH'(yv[0]), WIDTH'(yv[1]), WIDTH'(yv[2]), WIDTH'(yv[3]));
  endfunction

  // Monitor: pops the scoreboard on every output handshake; checks hold under stall.
  logic [4*(WIDTH+1)-1:0] prev_data;
  logic [2:0]             prev_mode;
  logic                   prev_stall = 1'b0;
  exp_t                   mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("hold_data", 128'(data_o), 128'(prev_data));
        check("hold_mode", 128'(out_mode), 128'(prev_mode));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0h mode %0d, expected no beat", data_o, out_mode);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 128'(data_o), 128'(mon_e.data));
          check("out_mode", 128'(out_mode), 128'(mon_e.mode));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= data_o;
      prev_mode  <= out_mode;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted; expected result pushed at acceptance.
  task automatic send(input logic [2:0] mode, input logic [4*WIDTH-1:0] d, input logic [6*WIDTH-1:0] zz,
                      input logic [4*(WIDTH+1)-1:0] exp_data, output int acc_edge);
    exp_t e;
    acc_edge = -1;
    mode_i   = mode;
    data_i   = d;
    zeta_i   = zz;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_edge = cyc + 1;
        e.mode   = mode;
        e.data   = exp_data;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no acceptance, expected acceptance of mode %0d", mode);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid && !busy) begin
        step();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending beats, expected 0", sb.size());
    step();
  endtask

  function automatic logic [4*WIDTH-1:0] vec(input int n);
    return {WIDTH'(8380410 - n), WIDTH'(n * 1000 + 7), WIDTH'(4190000 + n), WIDTH'(n + 1)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected completion");
    $fatal(1, "watchdog");
  end

  logic [6*WIDTH-1:0] z_one;
  logic [6*WIDTH-1:0] z_gen;
  int acc, acc1, acc2, acc_cnt, ov_cnt;

  initial begin
    z_one     = {6{WIDTH'(1)}};
    z_gen     = {WIDTH'(456), WIDTH'(123), WIDTH'(8380000), WIDTH'(77), WIDTH'(5), WIDTH'(3)};
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode_i    = 3'd0;
    data_i    = '0;
    zeta_i    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_data_o", 128'(data_o), 128'(0));
    check("rst_out_mode", 128'(out_mode), 128'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    step();

    // FWD directed vector with latency check
    send(3'd0, {WIDTH'(4), WIDTH'(3), WIDTH'(2), WIDTH'(1)}, z_one,
         pack4(23'd10, 23'd8380413, 23'd8380415, 23'd0), acc);
    for (int n = 0; n < L; n++) begin
      @(negedge clk);
      if (n == 0) check("busy_in_flight", 128'(busy), 128'(1));
      check("lat_early", 128'(out_valid), 128'(0));
    end
    @(negedge clk);
    check("lat_valid", 128'(out_valid), 128'(1));
    check("busy_cleared", 128'(busy), 128'(0));
    step();
    drain();

    // INV and PWM directed vectors
    send(3'd1, {WIDTH'(1), WIDTH'(2), WIDTH'(3), WIDTH'(5)}, z_one,
         pack4(23'd11, 23'd3, 23'd1, 23'd5), acc);
    drain();
    send(3'd2, {WIDTH'(4), WIDTH'(3), WIDTH'(2), WIDTH'(8380416)},
         {WIDTH'(456), WIDTH'(123), WIDTH'(7), WIDTH'(0), WIDTH'(5), WIDTH'(8380416)},
         pack4(23'd1, 23'd10, 23'd0, 23'd28), acc);
    drain();

    // Back-to-back same-mode beats: one per cycle
    acc1 = -1;
    for (int n = 0; n < 4; n++) begin
      send(3'd1, vec(n), z_gen, model(3'd1, vec(n), z_gen), acc);
      if (n > 0) check("throughput", 128'(acc), 128'(acc1 + 1));
      acc1 = acc;
    end
    drain();

    // Mode lock: INV held right after FWD waits for the FWD beat to reach the FIFO
    send(3'd0, vec(9), z_gen, model(3'd0, vec(9), z_gen), acc1);
    send(3'd1, vec(10), z_gen, model(3'd1, vec(10), z_gen), acc2);
    check("mode_lock_edge", 128'(acc2), 128'(acc1 + L));
    drain();

    // Backpressure: credit limit of FIFO_DEPTH beats
    out_ready = 1'b0;
    mode_i    = 3'd0;
    zeta_i    = z_gen;
    data_i    = vec(20);
    in_valid  = 1'b1;
    acc_cnt   = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_t'{mode: 3'd0, data: model(3'd0, data_i, zeta_i)});
        acc_cnt++;
      end
      step();
      data_i = vec(21 + n);
    end
    check("bp_accepted", 128'(acc_cnt), 128'(FIFO_DEPTH));
    @(negedge clk);
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_busy", 128'(busy), 128'(0));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("credit_pop_same_cycle", 128'(in_ready), 128'(0));
    step();
    @(negedge clk);
    check("credit_after_pop", 128'(in_ready), 128'(1));
    if (in_ready) sb.push_back(exp_t'{mode: 3'd0, data: model(3'd0, data_i, zeta_i)});
    step();
    in_valid = 1'b0;
    drain();

    // Reserved mode: zero result, sticky err
    send(3'd5, vec(3), z_gen, pack4(23'd0, 23'd0, 23'd0, 23'd0), acc);
    @(negedge clk);
    check("err_set", 128'(err), 128'(1));
    step();
    drain();
    check("err_sticky", 128'(err), 128'(1));

    // Reset mid-operation drops queued and in-flight beats
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) send(3'd0, vec(40 + n), z_gen, model(3'd0, vec(40 + n), z_gen), acc);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_err", 128'(err), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    ov_cnt    = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("no_stale_results", 128'(ov_cnt), 128'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
